ram_burst_ctrl: RTL
===================

# ram_burst_ctrl

Burst access controller sitting directly upstream of the team's 16x8 synchronous single-port RAM. It accepts a burst command (direction, start address, length) over a valid/ready handshake, then streams write beats into the RAM or read beats out of it. It drives the RAM's `wr`, `rd`, `add` and `din` pins and consumes its registered `dout`. A 2-entry skid buffer absorbs the RAM's 1-cycle read latency, so reads sustain 1 beat/cycle under backpressure.

## Interface
- `AW`, default 4: RAM address width, 16 locations.
- `DW`, default 8: data width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high; also drives the RAM's `rst`.
- `cmd_valid` / `cmd_ready`  in / out  1 / 1  command handshake.
- `cmd_wr`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  AW  start address.
- `cmd_len`  in  AW  beats minus 1, giving 1..16 beats.
- `wd_valid` / `wd_ready`  in / out  1 / 1  write-data handshake.
- `wd_data`  in  DW  write beat.
- `rd_valid` / `rd_ready`  out / in  1 / 1  read-data handshake.
- `rd_data`  out  DW  read beat.
- `ram_wr`, `ram_rd`  out  1  RAM strobes; never both high.
- `ram_add`  out  AW  RAM address.
- `ram_din`  out  DW  RAM write data; equals `wd_data`.
- `ram_dout`  in  DW  RAM registered read data.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse when a burst completes.
- `err`  out  1  one-cycle pulse on a rejected command; tied 0 without the macro.

## Operation
- FSM states: IDLE, WR, RD, RD_DRAIN.
- IDLE
  - `cmd_ready`=1.
  - On handshake: latch address pointer `ptr`=`cmd_addr` and remaining count `rem`=`cmd_len`+1 (5-bit).
  - Go to WR or RD.
- WR
  - `wd_ready`=1.
  - `ram_wr` = `wd_valid`; `ram_add` = `ptr`.
  - Each beat: `ptr`++ and `rem`--.
  - When `rem` reaches 0: pulse `done` the next cycle and go to IDLE.
- RD: issue read (`ram_rd`=1, `ram_add`=`ptr`) when `occ + inflight - pop < 2`.
  - `occ` = skid entries in use; `inflight` = `ram_rd` registered from last cycle; `pop` = `rd_valid && rd_ready`.
  - The data returned for an issued read (on `ram_dout` the following cycle) is pushed into the skid.
  - When the last read is issued, go to RD_DRAIN.
- RD_DRAIN: when `inflight`=0, `occ`=0 after the final pop, pulse `done` and go to IDLE.
- Address arithmetic is modulo 16: `ptr` wraps from 15 to 0.
- `rd_data` is the skid head; data order matches address order.
- A write beat is presented only while `wd_valid` is high; WR stalls indefinitely otherwise. RD likewise stalls while `rd_ready` is low.
- Reset, including mid-burst:
  - State returns to IDLE; skid, `inflight`, `ptr` and `rem` clear.
  - All outputs are 0 (`cmd_ready` is 0 during `rst`, 1 the cycle after).
  - The aborted burst produces no `done`. RAM contents are undefined for unwritten beats.

## Timing
- Command accepted at edge T; first `ram_wr` or `ram_rd` is in cycle T+1.
- Read: `ram_rd` in cycle T+1, `ram_dout` valid in T+2 and pushed, `rd_valid` from T+3. Latency from command to first data is 3 cycles.
- Throughput with `wd_valid` or `rd_ready` held high is 1 beat/cycle.
- `done` is asserted the cycle after the last write handshake, or after the last read pop. `cmd_ready` rises together with `done`.
- Outputs `ram_*`, `wd_ready` and `cmd_ready` are combinational from state and registers. `rd_valid` and `rd_data` are registered.

## Configuration
- Macro: `RAM_BURST_CTRL_BOUNDARY_ERR_EN`.
- Defined: a command with `cmd_addr + cmd_len > 15` is still handshaken, but gets `err`=1 the next cycle. The FSM stays in IDLE with no RAM access and no `done`.
- Undefined: such a burst wraps modulo 16 and `err` is constant 0.

## Structure
- Package `ram_ctrl_pkg` holds:
  - `AW`/`DW` defaults and the depth constant (16);
  - the state enum type;
  - the skid depth constant (2).
- Sub-module `ram_rd_skid`: 2-entry valid/ready buffer with push, pop, `occ` output and synchronous clear.

## Test plan
- Write burst: addr 2, len 3 (4 beats), data 0xA1..0xA4 -> `ram_wr` in 4 consecutive cycles at addresses 2..5; `done` the cycle after the last beat.
- Read burst: addr 2, len 3, `rd_ready`=1 -> `rd_data` 0xA1..0xA4 on consecutive cycles starting 3 cycles after the command; then `done`.
- Backpressure: 16-beat read with `rd_ready` toggled every 2 cycles -> no beat lost or duplicated, `occ` ≤ 2, order 0..15 preserved.
- Wrap, macro off: write addr 14, len 3 -> addresses 14, 15, 0, 1 are written; no `err`.
- Boundary, macro on: same command -> `err` pulse at T+1, no `ram_wr`, no `done`, `cmd_ready`=1.
- Reset mid-burst: `rst` asserted on the 3rd beat of an 8-beat read -> the next cycle shows `rd_valid`=0, `busy`=0 and no `done`; a following command executes normally.

Source files
------------

// File: rtl/ram_burst_ctrl_pkg.sv
// Shared constants and types for the RAM burst controller slice.
package ram_ctrl_pkg;

  localparam int RAM_AW     = 4;
  localparam int RAM_DW     = 8;
  localparam int RAM_DEPTH  = 16;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RD_DRAIN
  } state_t;

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Command, write-data, read-data and RAM pin bundle of the burst controller.
interface ram_burst_ctrl_if
  import ram_ctrl_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic          wd_valid;
  logic          wd_ready;
  logic [DW-1:0] wd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          ram_wr;
  logic          ram_rd;
  logic [AW-1:0] ram_add;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy;
  logic          done;
  logic          err;

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wd_valid, wd_data, rd_ready, ram_dout,
    output cmd_ready, wd_ready, rd_valid, rd_data, ram_wr, ram_rd, ram_add, ram_din,
           busy, done, err
  );

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wd_valid, wd_data, rd_ready, ram_dout,
    input  cmd_ready, wd_ready, rd_valid, rd_data, ram_wr, ram_rd, ram_add, ram_din,
           busy, done, err
  );

endinterface

// File: rtl/ram_rd_skid.sv
// Two-entry read-data skid buffer; registered head, push/pop in the same cycle allowed.
module ram_rd_skid
  import ram_ctrl_pkg::*;
#(
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic          vld,
  output logic [DW-1:0] head_dat,
  output logic [1:0]    occ
);

  logic [DW-1:0] mem [SKID_DEPTH];
  logic          wp;
  logic          rp;
  logic          do_pop;

  assign do_pop   = pop && (occ != 2'd0);
  assign vld      = (occ != 2'd0);
  assign head_dat = mem[rp];

  always_ff @(posedge clk) begin
    if (clr) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      occ <= 2'd0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= push_dat;
        wp      <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      if (push && !do_pop)      occ <= occ + 2'd1;
      else if (!push && do_pop) occ <= occ - 2'd1;
    end
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst controller for the 16x8 sync RAM: first read beat 3 cycles after command, 1 beat/cycle; stalls on
// wd_valid/rd_ready low. RAM_BURST_CTRL_BOUNDARY_ERR_EN rejects bursts crossing address 15 with an err pulse.
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic            clk,
  input  logic            rst,
  ram_burst_ctrl_if.slave bus
);

  localparam logic [AW:0]   REM_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] ptr;
  logic [AW:0]   rem;
  logic          inflight;
  logic          done_r;
  logic          err_r;
  logic [1:0]    occ;
  logic          skid_vld;
  logic [DW-1:0] skid_dat;
  logic          pop;
  logic          issue;
  logic          wd_hs;
  logic          last;
  logic          bad_cmd;
  logic          drain_done;

  assign pop   = skid_vld & bus.rd_ready;
  assign last  = (rem == REM_ONE);
  assign wd_hs = (state == WR) && bus.wd_valid;
  // Reads are issued only if the skid can still take the beat once it returns.
  assign issue = (state == RD) &&
                 (({1'b0, occ} + {2'b00, inflight}) < (3'(SKID_DEPTH) + {2'b00, pop}));
  assign drain_done = (state == RD_DRAIN) && !inflight &&
                      ((occ == 2'd0) || ((occ == 2'd1) && pop));

`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
  assign bad_cmd = ({1'b0, bus.cmd_addr} + {1'b0, bus.cmd_len}) > (AW+1)'(RAM_DEPTH - 1);
`else
  assign bad_cmd = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.cmd_valid && !bad_cmd) state_nxt = bus.cmd_wr ? WR : RD;
      WR:       if (wd_hs && last) state_nxt = IDLE;
      RD:       if (issue && last) state_nxt = RD_DRAIN;
      RD_DRAIN: if (drain_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      rem      <= '0;
      inflight <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      inflight <= issue;
      done_r   <= (wd_hs && last) || drain_done;
      err_r    <= (state == IDLE) && bus.cmd_valid && bad_cmd;
      if ((state == IDLE) && bus.cmd_valid) begin
        ptr <= bus.cmd_addr;
        rem <= {1'b0, bus.cmd_len} + REM_ONE;
      end else if (wd_hs || issue) begin
        ptr <= ptr + PTR_ONE;
        rem <= rem - REM_ONE;
      end
    end
  end

  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.wd_ready  = 1'b0;
    bus.ram_wr    = 1'b0;
    bus.ram_rd    = 1'b0;
    bus.ram_add   = '0;
    bus.ram_din   = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    if (!rst) begin
      bus.ram_add = ptr;
      bus.ram_din = bus.wd_data;
      bus.busy    = (state != IDLE);
      bus.done    = done_r;
      bus.err     = err_r;
      case (state)
        IDLE: bus.cmd_ready = 1'b1;
        WR: begin
          bus.wd_ready = 1'b1;
          bus.ram_wr   = bus.wd_valid;
        end
        RD:      bus.ram_rd = issue;
        default: ;
      endcase
    end
  end

  assign bus.rd_valid = skid_vld;
  assign bus.rd_data  = skid_dat;

  ram_rd_skid #(.DW(DW)) u_skid (
    .clk      (clk),
    .clr      (rst),
    .push     (inflight),
    .push_dat (bus.ram_dout),
    .pop      (pop),
    .vld      (skid_vld),
    .head_dat (skid_dat),
    .occ      (occ)
  );

endmodule
